// File: rtl/rx_frame_buf.sv
// Ping-pong receive frame buffer writer. Streams incoming bytes into one of
// two memory banks, commits complete frames, and drops bad or unplaceable ones.

module rx_frame_buf_chk (
  input logic       clk,
  input logic       rst_n,
  input logic       frame_irq,
  input logic [1:0] bank_full,
  input logic [15:0] drop_cnt
);

  a_irq_single: assert property (@(posedge clk) disable iff (!rst_n)
    frame_irq |=> !frame_irq);

  a_full0_on_commit: assert property (@(posedge clk) disable iff (!rst_n)
    $rose(bank_full[0]) |-> frame_irq);

  a_full1_on_commit: assert property (@(posedge clk) disable iff (!rst_n)
    $rose(bank_full[1]) |-> frame_irq);

  a_drop_monotonic: assert property (@(posedge clk) disable iff (!rst_n)
    drop_cnt >= $past(drop_cnt));

endmodule

module rx_frame_buf #(
  parameter int BANK_AW = 10
) (
  input  logic               RX_CLK,
  input  logic               rst_n,
  input  logic               in_data_v,
  input  logic [7:0]         in_data,
  input  logic               in_err,
  input  logic [1:0]         rel,
  output logic               mem_we,
  output logic [BANK_AW:0]   mem_addr,
  output logic [7:0]         mem_wdata,
  output logic               frame_irq,
  output logic [1:0]         bank_full,
  output logic [BANK_AW:0]   len0,
  output logic [BANK_AW:0]   len1,
  output logic [15:0]        drop_cnt
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_DROP  = 2'd2
  } state_e;

  localparam logic [BANK_AW:0] MAX_LEN = {1'b1, {BANK_AW{1'b0}}};
  localparam logic [BANK_AW:0] PTR_ONE = {{BANK_AW{1'b0}}, 1'b1};
  localparam logic [BANK_AW:0] PTR_ZERO = {(BANK_AW+1){1'b0}};

  state_e           state_q, state_d;
  logic             wr_bank_q, wr_bank_d;
  logic [BANK_AW:0] ptr_q, ptr_d;
  logic             prev_v_q, prev_v_d;
  logic             mem_we_q, mem_we_d;
  logic [BANK_AW:0] mem_addr_q, mem_addr_d;
  logic [7:0]       mem_wdata_q, mem_wdata_d;
  logic             frame_irq_q, frame_irq_d;
  logic [1:0]       bank_full_q, bank_full_d;
  logic [BANK_AW:0] len0_q, len0_d;
  logic [BANK_AW:0] len1_q, len1_d;
  logic [15:0]      drop_cnt_q, drop_cnt_d;
  logic             commit_s;
  logic             drop_inc_s;
  logic [1:0]       full_rel_s;

  // Frame FSM: byte placement, commit and drop decisions.
  always_comb begin
    state_d     = state_q;
    wr_bank_d   = wr_bank_q;
    ptr_d       = ptr_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    frame_irq_d = 1'b0;
    commit_s    = 1'b0;
    drop_inc_s  = 1'b0;
    // A frame may only start on a rising in_data_v; reset leaves prev_v set.
    prev_v_d    = in_data_v;

    case (state_q)
      S_IDLE: begin
        if (in_data_v && !prev_v_q) begin
          if (bank_full_q[wr_bank_q]) begin
            state_d    = S_DROP;
            drop_inc_s = 1'b1;
          end else begin
            state_d     = S_WRITE;
            mem_we_d    = 1'b1;
            mem_addr_d  = {wr_bank_q, {BANK_AW{1'b0}}};
            mem_wdata_d = in_data;
            ptr_d       = PTR_ONE;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WRITE: begin
        if (!in_data_v) begin
          commit_s    = 1'b1;
          frame_irq_d = 1'b1;
          wr_bank_d   = ~wr_bank_q;
          ptr_d       = PTR_ZERO;
          state_d     = S_IDLE;
        end else if (in_err || (ptr_q == MAX_LEN)) begin
          drop_inc_s = 1'b1;
          ptr_d      = PTR_ZERO;
          state_d    = S_DROP;
        end else begin
          mem_we_d    = 1'b1;
          mem_addr_d  = {wr_bank_q, ptr_q[BANK_AW-1:0]};
          mem_wdata_d = in_data;
          ptr_d       = ptr_q + PTR_ONE;
        end
      end
      S_DROP: begin
        if (!in_data_v) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DROP;
        end
      end
      default: begin
        state_d = S_IDLE;
        ptr_d   = PTR_ZERO;
      end
    endcase
  end

  // Bank bookkeeping: releases and commits land on the same edge.
  always_comb begin
    full_rel_s  = bank_full_q & ~rel;
    bank_full_d = full_rel_s;
    len0_d      = len0_q;
    len1_d      = len1_q;
    if (commit_s) begin
      bank_full_d[wr_bank_q] = 1'b1;
      if (wr_bank_q) begin
        len1_d = ptr_q;
      end else begin
        len0_d = ptr_q;
      end
    end else begin
      bank_full_d = full_rel_s;
    end
    if (drop_inc_s && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_d = drop_cnt_q + 16'd1;
    end else begin
      drop_cnt_d = drop_cnt_q;
    end
  end

  // State and output registers.
  always_ff @(posedge RX_CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      wr_bank_q   <= 1'b0;
      ptr_q       <= PTR_ZERO;
      prev_v_q    <= 1'b1;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= PTR_ZERO;
      mem_wdata_q <= 8'h00;
      frame_irq_q <= 1'b0;
      bank_full_q <= 2'b00;
      len0_q      <= PTR_ZERO;
      len1_q      <= PTR_ZERO;
      drop_cnt_q  <= 16'h0000;
    end else begin
      state_q     <= state_d;
      wr_bank_q   <= wr_bank_d;
      ptr_q       <= ptr_d;
      prev_v_q    <= prev_v_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      frame_irq_q <= frame_irq_d;
      bank_full_q <= bank_full_d;
      len0_q      <= len0_d;
      len1_q      <= len1_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign frame_irq = frame_irq_q;
  assign bank_full = bank_full_q;
  assign len0      = len0_q;
  assign len1      = len1_q;
  assign drop_cnt  = drop_cnt_q;

  rx_frame_buf_chk u_chk (
    .clk       (RX_CLK),
    .rst_n     (rst_n),
    .frame_irq (frame_irq_q),
    .bank_full (bank_full_q),
    .drop_cnt  (drop_cnt_q)
  );

endmodule

// File: tb/tb_rx_frame_buf.sv
// Scoreboard bench for rx_frame_buf: expected writes and commits are queued by
// the stimulus and consumed by a negedge monitor.

module tb_rx_frame_buf;

  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_data_v = 1'b0;
  logic [7:0]    in_data = 8'h00;
  logic          in_err = 1'b0;
  logic [1:0]    rel = 2'b00;
  logic          mem_we;
  logic [AW:0]   mem_addr;
  logic [7:0]    mem_wdata;
  logic          frame_irq;
  logic [1:0]    bank_full;
  logic [AW:0]   len0;
  logic [AW:0]   len1;
  logic [15:0]   drop_cnt;

  typedef struct packed {
    logic [AW:0] addr;
    logic [7:0]  data;
  } wr_t;

  typedef struct packed {
    logic        bank;
    logic [AW:0] len;
    logic [1:0]  full;
  } irq_t;

  wr_t  wr_q[$];
  irq_t irq_q[$];
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  rx_frame_buf #(.BANK_AW(AW)) dut (
    .RX_CLK    (clk),
    .rst_n     (rst_n),
    .in_data_v (in_data_v),
    .in_data   (in_data),
    .in_err    (in_err),
    .rel       (rel),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .frame_irq (frame_irq),
    .bank_full (bank_full),
    .len0      (len0),
    .len1      (len1),
    .drop_cnt  (drop_cnt)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every write and commit the DUT presents must match the queue head.
  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_we) begin
        if (wr_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_write: addr 0x%0h data 0x%0h with nothing expected", mem_addr, mem_wdata);
        end else begin
          wr_t e;
          e = wr_q.pop_front();
          check("wr_addr", 32'(mem_addr), 32'(e.addr));
          check("wr_data", 32'(mem_wdata), 32'(e.data));
        end
      end
      if (frame_irq) begin
        if (irq_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_irq: frame_irq high with no commit expected at %0t", $time);
        end else begin
          irq_t c;
          c = irq_q.pop_front();
          check("irq_len", c.bank ? 32'(len1) : 32'(len0), 32'(c.len));
          check("irq_full", 32'(bank_full), 32'(c.full));
        end
      end
    end
  end

  task automatic check_reset_vals();
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    check("rst_irq", 32'(frame_irq), 32'd0);
    check("rst_full", 32'(bank_full), 32'd0);
    check("rst_len0", 32'(len0), 32'd0);
    check("rst_len1", 32'(len1), 32'd0);
    check("rst_drop", 32'(drop_cnt), 32'd0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    in_data_v = 1'b0;
    in_err    = 1'b0;
    rel       = 2'b00;
    rst_n     = 1'b0;
    #1;
    check_reset_vals();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic pulse_rel(input logic [1:0] r);
    rel = r;
    @(posedge clk); #1;
    rel = 2'b00;
    @(posedge clk); #1;
  endtask

  // n bytes starting at value start; err_at marks the errored byte (-1 none).
  task automatic send_frame(input int n, input int start, input int err_at,
                            input int exp_writes, input logic bank,
                            input logic commit, input logic [1:0] exp_full,
                            input logic [1:0] rel_c);
    wr_t  w;
    irq_t c;
    for (int i = 0; i < n; i++) begin
      in_data_v = 1'b1;
      in_data   = 8'(start + i);
      in_err    = (i == err_at);
      if (i < exp_writes) begin
        w.addr = {bank, AW'(i)};
        w.data = 8'(start + i);
        wr_q.push_back(w);
      end
      @(posedge clk); #1;
    end
    in_data_v = 1'b0;
    in_err    = 1'b0;
    rel       = rel_c;
    if (commit) begin
      c.bank = bank;
      c.len  = (AW+1)'(n);
      c.full = exp_full;
      irq_q.push_back(c);
    end
    @(posedge clk); #1;
    rel = 2'b00;
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    wr_t w;
    // Power-on reset
    #2;
    check_reset_vals();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // 60-byte frame into bank 0, then next frame must go to bank 1
    send_frame(60, 0, -1, 60, 1'b0, 1'b1, 2'b01, 2'b00);
    check("a_len0", 32'(len0), 32'd60);
    check("a_full", 32'(bank_full), 32'h1);
    check("a_drop", 32'(drop_cnt), 32'd0);
    send_frame(8, 8'hA0, -1, 8, 1'b1, 1'b1, 2'b11, 2'b00);
    check("a_len1", 32'(len1), 32'd8);

    // Three 64-byte frames with no release: third dropped
    do_reset();
    send_frame(64, 8'h40, -1, 64, 1'b0, 1'b1, 2'b01, 2'b00);
    send_frame(64, 8'h80, -1, 64, 1'b1, 1'b1, 2'b11, 2'b00);
    send_frame(64, 8'hC0, -1, 0, 1'b0, 1'b0, 2'b11, 2'b00);
    check("b_drop", 32'(drop_cnt), 32'd1);
    check("b_full", 32'(bank_full), 32'h3);
    check("b_len0", 32'(len0), 32'd64);
    check("b_len1", 32'(len1), 32'd64);

    // Release bank 0, refill it; then commit bank 1 while releasing bank 0
    pulse_rel(2'b01);
    check("c_full_rel0", 32'(bank_full), 32'h2);
    send_frame(16, 8'h10, -1, 16, 1'b0, 1'b1, 2'b11, 2'b00);
    check("c_len0", 32'(len0), 32'd16);
    pulse_rel(2'b10);
    check("c_full_rel1", 32'(bank_full), 32'h1);
    send_frame(20, 8'h20, -1, 20, 1'b1, 1'b1, 2'b10, 2'b01);
    check("c_full_both", 32'(bank_full), 32'h2);
    check("c_len1", 32'(len1), 32'd20);
    check("c_len0_kept", 32'(len0), 32'd16);
    pulse_rel(2'b01);
    check("c_rel_nonfull", 32'(bank_full), 32'h2);

    // Error at byte 10 of a 40-byte frame; retry lands in same bank
    do_reset();
    send_frame(40, 0, 10, 10, 1'b0, 1'b0, 2'b00, 2'b00);
    check("d_drop", 32'(drop_cnt), 32'd1);
    check("d_full", 32'(bank_full), 32'h0);
    check("d_len0", 32'(len0), 32'd0);
    send_frame(12, 8'h55, -1, 12, 1'b0, 1'b1, 2'b01, 2'b00);
    check("d_len0_retry", 32'(len0), 32'd12);

    // Maximum-length frame commits, one byte longer is dropped
    do_reset();
    send_frame(1024, 0, -1, 1024, 1'b0, 1'b1, 2'b01, 2'b00);
    check("e_len0_max", 32'(len0), 32'd1024);
    send_frame(1025, 7, -1, 1024, 1'b1, 1'b0, 2'b01, 2'b00);
    check("e_drop", 32'(drop_cnt), 32'd1);
    check("e_full", 32'(bank_full), 32'h1);
    check("e_len1", 32'(len1), 32'd0);
    check("e_len0_kept", 32'(len0), 32'd1024);
    send_frame(5, 8'hE0, -1, 5, 1'b1, 1'b1, 2'b11, 2'b00);
    check("e_len1_after", 32'(len1), 32'd5);

    // Reset mid-frame, released while in_data_v still high
    do_reset();
    for (int i = 0; i < 20; i++) begin
      in_data_v = 1'b1;
      in_data   = 8'(8'h90 + i);
      w.addr    = {1'b0, AW'(i)};
      w.data    = 8'(8'h90 + i);
      wr_q.push_back(w);
      @(posedge clk); #1;
    end
    in_data = 8'hEE;
    @(negedge clk); #1;
    rst_n = 1'b0;
    #1;
    check_reset_vals();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_data = 8'(8'hB0 + i);
      @(posedge clk); #1;
    end
    in_data_v = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("f_drop", 32'(drop_cnt), 32'd0);
    check("f_full", 32'(bank_full), 32'h0);
    send_frame(8, 8'h30, -1, 8, 1'b0, 1'b1, 2'b01, 2'b00);
    check("f_len0", 32'(len0), 32'd8);

    repeat (5) @(posedge clk);
    #1;
    check("wr_q_empty", 32'(wr_q.size()), 32'd0);
    check("irq_q_empty", 32'(irq_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
